// File: rtl/qerv_mdu_if.sv
// qerv_mdu_if: request/response bundle between the qerv core and its MDU.
// master = core side (drives request), slave = MDU side (drives result).
interface qerv_mdu_if;
    logic        i_mdu_valid;
    logic [31:0] i_ext_rs1;
    logic [31:0] i_ext_rs2;
    logic [2:0]  i_ext_funct3;
    logic [31:0] o_ext_rd;
    logic        o_ext_ready;

    modport master (
        output i_mdu_valid, i_ext_rs1, i_ext_rs2, i_ext_funct3,
        input  o_ext_rd, o_ext_ready
    );

    modport slave (
        input  i_mdu_valid, i_ext_rs1, i_ext_rs2, i_ext_funct3,
        output o_ext_rd, o_ext_ready
    );
endinterface

// File: rtl/qerv_mdu.sv
// qerv_mdu: iterative RV32M multiply/divide responder, one bit per clock.
// Multiply is LSB-first shift-add, divide is MSB-first restoring division,
// both on operand magnitudes with sign fix-up in a final FIX cycle.
// Define QERV_MDU_DIV_EN to include the divider; without it (Zmmul build)
// divide requests complete with a zero result.
module qerv_mdu (
    input  logic      clk,
    input  logic      i_rst_n,
    qerv_mdu_if.slave mdu
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [2:0]  f3;
    logic [31:0] opnd;   // multiplicand |A| or divisor |B|
    logic [63:0] acc;    // mul: {partial, multiplier}; div: {remainder, quotient}
    logic        neg;    // result needs negation
    logic [4:0]  cnt;

    logic        in_div, sa, sb, a_neg, b_neg, neg_in;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [63:0] step;
    logic [63:0] prod_fix;
    logic [31:0] mul_res;
    logic [31:0] result;
`ifdef QERV_MDU_DIV_EN
    logic [32:0] r_sh, diff;
    logic        q_bit;
    logic [31:0] div_sel;
`endif

    // Request decode: operand signedness, magnitudes and result sign
    always_comb begin
        in_div = mdu.i_ext_funct3[2];
        sa     = in_div ? ~mdu.i_ext_funct3[0]
                        : (mdu.i_ext_funct3[1:0] == 2'b01) || (mdu.i_ext_funct3[1:0] == 2'b10);
        sb     = in_div ? ~mdu.i_ext_funct3[0] : (mdu.i_ext_funct3[1:0] == 2'b01);
        a_neg  = sa & mdu.i_ext_rs1[31];
        b_neg  = sb & mdu.i_ext_rs2[31];
        a_mag  = a_neg ? (~mdu.i_ext_rs1 + 32'd1) : mdu.i_ext_rs1;
        b_mag  = b_neg ? (~mdu.i_ext_rs2 + 32'd1) : mdu.i_ext_rs2;
        if (!in_div)
            neg_in = a_neg ^ b_neg;
        else if (mdu.i_ext_funct3[1])
            neg_in = a_neg;
        else
            neg_in = (a_neg ^ b_neg) && (mdu.i_ext_rs2 != '0);
    end

    // One iteration of the shift-add multiplier or restoring divider
    always_comb begin
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        step    = {mul_sum, acc[31:1]};
`ifdef QERV_MDU_DIV_EN
        r_sh  = {acc[63:32], acc[31]};
        diff  = r_sh - {1'b0, opnd};
        q_bit = ~diff[32];
        if (f3[2])
            step = {q_bit ? diff[31:0] : r_sh[31:0], acc[30:0], q_bit};
`endif
    end

    // Sign correction and result select for the FIX cycle
    always_comb begin
        prod_fix = neg ? (~acc + 64'd1) : acc;
        mul_res  = (f3[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
`ifdef QERV_MDU_DIV_EN
        div_sel  = f3[1] ? acc[63:32] : acc[31:0];
        result   = f3[2] ? (neg ? (~div_sel + 32'd1) : div_sel) : mul_res;
`else
        result   = f3[2] ? '0 : mul_res;
`endif
    end

    // Controller and datapath registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            f3              <= '0;
            opnd            <= '0;
            acc             <= '0;
            neg             <= 1'b0;
            cnt             <= '0;
            mdu.o_ext_rd    <= '0;
            mdu.o_ext_ready <= 1'b0;
        end else begin
            mdu.o_ext_ready <= 1'b0;
            case (state)
                IDLE: if (mdu.i_mdu_valid) begin
                    f3  <= mdu.i_ext_funct3;
                    neg <= neg_in;
                    cnt <= '0;
                    if (in_div) begin
                        opnd <= b_mag;
                        acc  <= {32'd0, a_mag};
                    end else begin
                        opnd <= a_mag;
                        acc  <= {32'd0, b_mag};
                    end
`ifdef QERV_MDU_DIV_EN
                    state <= CALC;
`else
                    // Divide skips CALC; FIX supplies the zero result so
                    // ready lands two edges after acceptance.
                    state <= in_div ? FIX : CALC;
`endif
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    mdu.o_ext_rd    <= result;
                    mdu.o_ext_ready <= 1'b1;
                    state           <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
